parking_lot_multi_gate: RTL and testbench

Parametrised occupancy tracker for a lot with NUM_GATES independent two-sensor gates (outer/inner beam per gate).
- Per gate: synchronises the raw sensor switches, runs a direction-detecting FSM, and emits one-cycle enter/exit events.
- Events from all gates merge into a single saturating occupancy counter with full/empty/error flags.
- Sits under the board top level; sensor bits come from V_GPIO switches, and outputs drive the LEDs and the 7-seg decode logic.

---
 rtl/parking_lot_multi_gate.sv | 206 ++++++++++++++++++++
 tb/tb_parking_lot_multi_gate.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_multi_gate.sv
// Multi-gate parking lot occupancy tracker: per-gate 2-flop sensor sync and direction FSM, merged into a saturating counter.
// Define PARKING_DEBOUNCE_EN to insert a DEB_CYCLES debounce stage after each synchroniser.
module parking_lot_multi_gate #(
    parameter int NUM_GATES  = 2,
    parameter int CAPACITY   = 25,
    parameter int CNT_W      = $clog2(CAPACITY + 1),
    parameter int DEB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] outer,
    input  logic [NUM_GATES-1:0] inner,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic [NUM_GATES-1:0] enter_pulse,
    output logic [NUM_GATES-1:0] exit_pulse,
    output logic                 clamp_err
);

    localparam int SUM_W = CNT_W + 4;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

    typedef enum logic [2:0] {
        IDLE,
        E1,
        E2,
        E3,
        X1,
        X2,
        X3,
        BAD
    } state_t;

    logic [NUM_GATES-1:0] outer_m, inner_m;
    logic [NUM_GATES-1:0] outer_s, inner_s;
    logic [NUM_GATES-1:0] outer_f, inner_f;
    state_t               state [NUM_GATES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outer_m <= '0;
            inner_m <= '0;
            outer_s <= '0;
            inner_s <= '0;
        end else begin
            outer_m <= outer;
            inner_m <= inner;
            outer_s <= outer_m;
            inner_s <= inner_m;
        end
    end

`ifdef PARKING_DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [DW-1:0] outer_cnt [NUM_GATES];
    logic [DW-1:0] inner_cnt [NUM_GATES];

    // A filtered bit follows the synchronised bit only after DEB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outer_f <= '0;
            inner_f <= '0;
            for (int unsigned g = 0; g < NUM_GATES; g++) begin
                outer_cnt[g] <= '0;
                inner_cnt[g] <= '0;
            end
        end else begin
            for (int unsigned g = 0; g < NUM_GATES; g++) begin
                if (outer_s[g] != outer_f[g]) begin
                    if (outer_cnt[g] == DW'(DEB_CYCLES - 1)) begin
                        outer_f[g]   <= outer_s[g];
                        outer_cnt[g] <= '0;
                    end else begin
                        outer_cnt[g] <= outer_cnt[g] + 1'b1;
                    end
                end else begin
                    outer_cnt[g] <= '0;
                end

                if (inner_s[g] != inner_f[g]) begin
                    if (inner_cnt[g] == DW'(DEB_CYCLES - 1)) begin
                        inner_f[g]   <= inner_s[g];
                        inner_cnt[g] <= '0;
                    end else begin
                        inner_cnt[g] <= inner_cnt[g] + 1'b1;
                    end
                end else begin
                    inner_cnt[g] <= '0;
                end
            end
        end
    end
`else
    assign outer_f = outer_s;
    assign inner_f = inner_s;
`endif

    // s = {outer, inner}; exit states mirror entry states with the sensor roles swapped.
    function automatic state_t next_state(input state_t cur, input logic [1:0] s);
        next_state = cur;
        case (cur)
            IDLE: case (s)
                2'b10: next_state = E1;
                2'b01: next_state = X1;
                2'b11: next_state = BAD;
                default: next_state = IDLE;
            endcase
            E1: case (s)
                2'b11: next_state = E2;
                2'b00: next_state = IDLE;
                default: next_state = E1;
            endcase
            E2: case (s)
                2'b01: next_state = E3;
                2'b10: next_state = E1;
                2'b00: next_state = BAD;
                default: next_state = E2;
            endcase
            E3: case (s)
                2'b00: next_state = IDLE;
                2'b11: next_state = E2;
                2'b10: next_state = BAD;
                default: next_state = E3;
            endcase
            X1: case (s)
                2'b11: next_state = X2;
                2'b00: next_state = IDLE;
                default: next_state = X1;
            endcase
            X2: case (s)
                2'b10: next_state = X3;
                2'b01: next_state = X1;
                2'b00: next_state = BAD;
                default: next_state = X2;
            endcase
            X3: case (s)
                2'b00: next_state = IDLE;
                2'b11: next_state = X2;
                2'b01: next_state = BAD;
                default: next_state = X3;
            endcase
            BAD: next_state = (s == 2'b00) ? IDLE : BAD;
            default: next_state = IDLE;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_pulse <= '0;
            exit_pulse  <= '0;
            for (int unsigned g = 0; g < NUM_GATES; g++) begin
                state[g] <= IDLE;
            end
        end else begin
            for (int unsigned g = 0; g < NUM_GATES; g++) begin
                state[g]       <= next_state(state[g], {outer_f[g], inner_f[g]});
                enter_pulse[g] <= (state[g] == E3) && ({outer_f[g], inner_f[g]} == 2'b00);
                exit_pulse[g]  <= (state[g] == X3) && ({outer_f[g], inner_f[g]} == 2'b00);
            end
        end
    end

    function automatic logic [3:0] popcount(input logic [NUM_GATES-1:0] v);
        popcount = '0;
        for (int unsigned i = 0; i < NUM_GATES; i++) begin
            popcount = popcount + 4'(v[i]);
        end
    endfunction

    logic signed [SUM_W-1:0] sum;
    logic [CNT_W-1:0]        next_count;
    logic                    clamp_hit;

    always_comb begin
        sum        = SUM_W'(count) + SUM_W'(popcount(enter_pulse)) - SUM_W'(popcount(exit_pulse));
        next_count = count;
        clamp_hit  = 1'b0;
        if (sum < 0) begin
            next_count = '0;
            clamp_hit  = 1'b1;
        end else if (sum > CAP_S) begin
            next_count = CNT_W'(CAPACITY);
            clamp_hit  = 1'b1;
        end else begin
            next_count = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            clamp_err <= 1'b0;
        end else begin
            count <= next_count;
            if (clamp_hit) begin
                clamp_err <= 1'b1;
            end
        end
    end

    assign full  = (count == CNT_W'(CAPACITY));
    assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_multi_gate.sv
// Directed bench for parking_lot_multi_gate (2 gates, capacity 3); adapts hold/latency when PARKING_DEBOUNCE_EN is defined.
module tb_parking_lot_multi_gate;

    localparam int NG  = 2;
    localparam int CAP = 3;
    localparam int CW  = $clog2(CAP + 1);
    localparam int DEB = 4;
`ifdef PARKING_DEBOUNCE_EN
    localparam int EXTRA = DEB;
`else
    localparam int EXTRA = 0;
`endif
    localparam int HOLD = 3 + EXTRA;
    localparam int LAT  = 3 + EXTRA;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NG-1:0] outer = '0;
    logic [NG-1:0] inner = '0;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [NG-1:0] enter_pulse;
    logic [NG-1:0] exit_pulse;
    logic          clamp_err;

    int checks = 0;
    int errors = 0;
    logic [NG-1:0] seen_enter = '0;
    logic [NG-1:0] seen_exit  = '0;

    parking_lot_multi_gate #(
        .NUM_GATES (NG),
        .CAPACITY  (CAP),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .outer      (outer),
        .inner      (inner),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .enter_pulse(enter_pulse),
        .exit_pulse (exit_pulse),
        .clamp_err  (clamp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        seen_enter = seen_enter | enter_pulse;
        seen_exit  = seen_exit | exit_pulse;
    endtask

    task automatic hold(input logic [NG-1:0] o, input logic [NG-1:0] i, input int n);
        outer = o;
        inner = i;
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic traverse(input logic [NG-1:0] m, input bit entering);
        if (entering) begin
            hold(m, '0, HOLD);
            hold(m, m, HOLD);
            hold('0, m, HOLD);
        end else begin
            hold('0, m, HOLD);
            hold(m, m, HOLD);
            hold(m, '0, HOLD);
        end
        hold('0, '0, LAT + 2);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_pulses", 32'({enter_pulse, exit_pulse}), 0);
        chk("rst_clamp", 32'(clamp_err), 0);
        reset = 1'b1;
        tick();

        // Gate0 entry with exact pulse latency
        hold(2'b01, 2'b00, HOLD);
        hold(2'b01, 2'b01, HOLD);
        hold(2'b00, 2'b01, HOLD);
        outer = '0;
        inner = '0;
        repeat (LAT - 1) tick();
        chk("t1_pre_pulse", 32'(enter_pulse), 0);
        tick();
        chk("t1_pulse", 32'(enter_pulse), 32'h1);
        chk("t1_count_before", 32'(count), 0);
        chk("t1_empty_before", 32'(empty), 1);
        tick();
        chk("t1_pulse_gone", 32'(enter_pulse), 0);
        chk("t1_count", 32'(count), 1);
        chk("t1_empty", 32'(empty), 0);

        // Gate1 exit
        seen_enter = '0;
        seen_exit  = '0;
        traverse(2'b10, 1'b0);
        chk("t2_exit", 32'(seen_exit), 32'h2);
        chk("t2_no_enter", 32'(seen_enter), 0);
        chk("t2_count", 32'(count), 0);
        chk("t2_empty", 32'(empty), 1);
        chk("t2_clamp", 32'(clamp_err), 0);

        // Back-out, then BAD ignores a full sequence until 00
        seen_enter = '0;
        seen_exit  = '0;
        hold(2'b01, 2'b00, HOLD);
        hold(2'b01, 2'b01, HOLD);
        hold(2'b01, 2'b00, HOLD);
        hold(2'b00, 2'b00, HOLD);
        hold(2'b01, 2'b01, HOLD);
        hold(2'b01, 2'b00, HOLD);
        hold(2'b01, 2'b01, HOLD);
        hold(2'b00, 2'b01, HOLD);
        hold(2'b00, 2'b00, LAT + 2);
        chk("t3_no_pulse", 32'({seen_enter, seen_exit}), 0);
        chk("t3_count", 32'(count), 0);
        traverse(2'b01, 1'b1);
        chk("t3_enter_after_bad", 32'(seen_enter), 32'h1);
        chk("t3_count_after", 32'(count), 1);

        // Fill to capacity, then overflow
        traverse(2'b01, 1'b1);
        traverse(2'b01, 1'b1);
        chk("t4_count_full", 32'(count), 3);
        chk("t4_full", 32'(full), 1);
        chk("t4_clamp_pre", 32'(clamp_err), 0);
        seen_enter = '0;
        traverse(2'b01, 1'b1);
        chk("t4_enter_at_full", 32'(seen_enter), 32'h1);
        chk("t4_count_sat", 32'(count), 3);
        chk("t4_clamp", 32'(clamp_err), 1);
        traverse(2'b10, 1'b0);
        chk("t4_count_exit", 32'(count), 2);
        chk("t4_full_clear", 32'(full), 0);
        chk("t4_clamp_sticky", 32'(clamp_err), 1);

        // Simultaneous entry on gate0 and exit on gate1
        hold(2'b01, 2'b10, HOLD);
        hold(2'b11, 2'b11, HOLD);
        hold(2'b10, 2'b01, HOLD);
        outer = '0;
        inner = '0;
        repeat (LAT) tick();
        chk("t5_enter", 32'(enter_pulse), 32'h1);
        chk("t5_exit", 32'(exit_pulse), 32'h2);
        tick();
        chk("t5_count", 32'(count), 2);

        // Reset while gate0 is mid-entry
        hold(2'b01, 2'b00, HOLD);
        hold(2'b01, 2'b01, HOLD);
        outer = '0;
        inner = '0;
        reset = 1'b0;
        #1;
        chk("t6_async_count", 32'(count), 0);
        tick();
        tick();
        chk("t6_count", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_full", 32'(full), 0);
        chk("t6_pulses", 32'({enter_pulse, exit_pulse}), 0);
        chk("t6_clamp", 32'(clamp_err), 0);
        reset = 1'b1;
        seen_enter = '0;
        seen_exit  = '0;
        repeat (LAT + 4) tick();
        chk("t6_no_pulse", 32'({seen_enter, seen_exit}), 0);
        chk("t6_count_after", 32'(count), 0);

`ifdef PARKING_DEBOUNCE_EN
        // Short glitch on outer must be filtered
        hold(2'b01, 2'b00, 2);
        hold(2'b00, 2'b00, LAT + 4);
        chk("deb_glitch", 32'({seen_enter, seen_exit}), 0);
        chk("deb_count", 32'(count), 0);
`endif

        // Exit at empty clamps at zero
        traverse(2'b10, 1'b0);
        chk("uf_exit", 32'(seen_exit), 32'h2);
        chk("uf_count", 32'(count), 0);
        chk("uf_empty", 32'(empty), 1);
        chk("uf_clamp", 32'(clamp_err), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
